// File: rtl/pc_sequencer.sv
// pc_sequencer: start/run/halt PC sequencer with target LUT, relative branches and a bounded return stack
module pc_sequencer #(
  parameter int PC_W        = 10,
  parameter int LUT_AW      = 5,
  parameter int STACK_DEPTH = 4,
  parameter int START_PC    = 0
) (
  input  logic              CLK,
  input  logic              Init,
  input  logic              Start,
  input  logic              Halt,
  input  logic              Stall,
  input  logic              BRANCH,
  input  logic              Cond,
  input  logic [1:0]        BrMode,
  input  logic [LUT_AW-1:0] LutIdx,
  input  logic [7:0]        Offset,
  input  logic              LutWe,
  input  logic [LUT_AW-1:0] LutWaddr,
  input  logic [PC_W-1:0]   LutWdata,
  output logic [PC_W-1:0]   PC,
  output logic              Running,
  output logic              Done,
  output logic              StackErr
);
  localparam int SPW = $clog2(STACK_DEPTH + 1);
  localparam int IW  = STACK_DEPTH > 1 ? $clog2(STACK_DEPTH) : 1;
  localparam logic [PC_W-1:0] START = PC_W'(START_PC);
  typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;
  state_t state;
  logic [PC_W-1:0] lut [2**LUT_AW];
  logic [PC_W-1:0] stack [STACK_DEPTH];
  logic [SPW-1:0] sp;
  logic [PC_W-1:0] pc_inc, pc_rel, target;
  logic [IW-1:0] push_idx, top_idx;
  logic full, empty, taken;
  assign pc_inc   = PC + 1'b1;
  assign pc_rel   = PC + PC_W'($signed(Offset));
  assign target   = lut[LutIdx];
  assign push_idx = IW'(sp);
  assign top_idx  = IW'(sp - 1'b1);
  assign full     = sp == SPW'(STACK_DEPTH);
  assign empty    = sp == '0;
  assign taken    = BRANCH & Cond;
  always_ff @(posedge CLK) begin
    if (Init) begin
      state    <= IDLE;
      PC       <= START;
      sp       <= '0;
      StackErr <= 1'b0;
      Running  <= 1'b0;
      Done     <= 1'b0;
      lut      <= '{default: '0};
    end else begin
      if (LutWe) lut[LutWaddr] <= LutWdata;
      case (state)
        IDLE: if (Start) begin
          state   <= RUN;
          Running <= 1'b1;
          PC      <= START;
        end
        RUN: if (Halt) begin
          state   <= HALTED;
          Running <= 1'b0;
          Done    <= 1'b1;
        end else if (!Stall) begin
          if (!taken) PC <= pc_inc;
          else case (BrMode)
            2'b00: PC <= target;
            2'b01: PC <= pc_rel;
            2'b10: if (full) begin
              PC       <= pc_inc;
              StackErr <= 1'b1;
            end else begin
              stack[push_idx] <= pc_inc;
              sp              <= sp + 1'b1;
              PC              <= target;
            end
            default: if (empty) begin
              PC       <= pc_inc;
              StackErr <= 1'b1;
            end else begin
              PC <= stack[top_idx];
              sp <= sp - 1'b1;
            end
          endcase
        end
        HALTED: if (Start) begin
          state    <= RUN;
          Running  <= 1'b1;
          Done     <= 1'b0;
          PC       <= START;
          sp       <= '0;
          StackErr <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: scoreboard bench; each row's expected PC/flags are queued as it is driven and checked one cycle later
module tb_pc_sequencer;
  logic CLK = 1'b0;
  logic Init, Start, Halt, Stall, BRANCH, Cond, LutWe;
  logic [1:0] BrMode;
  logic [4:0] LutIdx, LutWaddr;
  logic [7:0] Offset;
  logic [9:0] LutWdata, PC;
  logic Running, Done, StackErr;
  int checks = 0;
  int failures = 0;

  pc_sequencer dut (
    .CLK(CLK), .Init(Init), .Start(Start), .Halt(Halt), .Stall(Stall),
    .BRANCH(BRANCH), .Cond(Cond), .BrMode(BrMode), .LutIdx(LutIdx), .Offset(Offset),
    .LutWe(LutWe), .LutWaddr(LutWaddr), .LutWdata(LutWdata),
    .PC(PC), .Running(Running), .Done(Done), .StackErr(StackErr)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string nm;
    logic [5:0] f;
    logic [1:0] m;
    logic [4:0] ix;
    logic [7:0] of;
    logic [9:0] pc;
    logic ru, dn, er;
  } row_t;
  typedef struct {
    string nm;
    logic [9:0] pc;
    logic ru, dn, er;
  } exp_t;
  row_t rows[$];
  exp_t sb[$];
  exp_t e;

  // flag bits: {init, start, halt, stall, branch, cond}
  localparam logic [5:0] IN = 6'b100000, ST = 6'b010000, HL = 6'b001000,
                         SL = 6'b000100, BR = 6'b000011, BN = 6'b000010;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic add(input string nm, input logic [5:0] f, input logic [1:0] m,
                     input logic [4:0] ix, input logic [7:0] of,
                     input logic [9:0] pc, input logic ru, input logic dn, input logic er);
    rows.push_back('{nm, f, m, ix, of, pc, ru, dn, er});
  endtask

  task automatic apply(input row_t r);
    {Init, Start, Halt, Stall, BRANCH, Cond} = r.f;
    BrMode = r.m;
    LutIdx = r.ix;
    Offset = r.of;
    sb.push_back('{r.nm, r.pc, r.ru, r.dn, r.er});
  endtask

  task automatic restart();
    {Init, Start, Halt, Stall, BRANCH, Cond, LutWe} = 7'b1000000;
    tick();
    Init = 1'b0;
  endtask

  task automatic lut_wr(input logic [4:0] a, input logic [9:0] d);
    LutWe = 1'b1;
    LutWaddr = a;
    LutWdata = d;
    tick();
    LutWe = 1'b0;
  endtask

  task automatic test_reset();
    {Init, Start, Halt, Stall, BRANCH, Cond} = 6'b101011;
    BrMode = 2'b00;
    LutIdx = 5'd1;
    Offset = 8'h10;
    LutWe = 1'b0;
    tick();
    checks++;
    if ({PC, Running, Done, StackErr} !== {10'd0, 3'b000}) begin
      failures++;
      $display("FAIL reset: got pc=%0h run=%0b done=%0b err=%0b, want pc=0 run=0 done=0 err=0", PC, Running, Done, StackErr);
    end
    Init = 1'b0;
    tick();
    checks++;
    if ({PC, Running, Done, StackErr} !== {10'd0, 3'b000}) begin
      failures++;
      $display("FAIL idle_hold: got pc=%0h run=%0b done=%0b err=%0b, want pc=0 run=0 done=0 err=0", PC, Running, Done, StackErr);
    end
  endtask

  task automatic test_seq_wrap();
    restart();
    add("start", ST, 0, 0, 0, 10'd0, 1, 0, 0);
    for (int i = 1; i <= 1024; i++) add("wrap", 0, 0, 0, 0, 10'(i), 1, 0, 0);
    for (int i = 1; i <= 5; i++) add("step", 0, 0, 0, 0, 10'(i), 1, 0, 0);
    add("halt", HL, 0, 0, 0, 10'd5, 0, 1, 0);
    add("halted_hold", 0, 0, 0, 0, 10'd5, 0, 1, 0);
    add("halted_ignore", HL | BR, 0, 1, 0, 10'd5, 0, 1, 0);
    while (rows.size() > 0) begin
      apply(rows.pop_front());
      tick();
      e = sb.pop_front();
      checks++;
      if ({PC, Running, Done, StackErr} !== {e.pc, e.ru, e.dn, e.er}) begin
        failures++;
        $display("FAIL %s: got pc=%0h run=%0b done=%0b err=%0b, want pc=%0h run=%0b done=%0b err=%0b",
                 e.nm, PC, Running, Done, StackErr, e.pc, e.ru, e.dn, e.er);
      end
    end
  endtask

  task automatic test_branches();
    restart();
    lut_wr(5'd3, 10'h2A);
    add("start", ST, 0, 0, 0, 10'd0, 1, 0, 0);
    for (int i = 1; i <= 4; i++) add("step", 0, 0, 0, 0, 10'(i), 1, 0, 0);
    add("abs", BR, 2'b00, 5'd3, 0, 10'h2A, 1, 0, 0);
    add("rel_neg", BR, 2'b01, 0, 8'hFE, 10'h28, 1, 0, 0);
    add("abs_nt", BN, 2'b00, 5'd3, 0, 10'h29, 1, 0, 0);
    add("rel_nt", BN, 2'b01, 0, 8'hFE, 10'h2A, 1, 0, 0);
    add("rel_pos", BR, 2'b01, 0, 8'h05, 10'h2F, 1, 0, 0);
    add("rel_min_wrap", BR, 2'b01, 0, 8'h80, 10'h3AF, 1, 0, 0);
    add("rel_max_wrap", BR, 2'b01, 0, 8'h7F, 10'h2E, 1, 0, 0);
    add("cond_no_branch", 6'b000001, 2'b00, 5'd3, 0, 10'h2F, 1, 0, 0);
    while (rows.size() > 0) begin
      apply(rows.pop_front());
      tick();
      e = sb.pop_front();
      checks++;
      if ({PC, Running, Done, StackErr} !== {e.pc, e.ru, e.dn, e.er}) begin
        failures++;
        $display("FAIL %s: got pc=%0h run=%0b done=%0b err=%0b, want pc=%0h run=%0b done=%0b err=%0b",
                 e.nm, PC, Running, Done, StackErr, e.pc, e.ru, e.dn, e.er);
      end
    end
  endtask

  task automatic test_call_return();
    restart();
    lut_wr(5'd1, 10'd10);
    lut_wr(5'd2, 10'd20);
    lut_wr(5'd4, 10'd30);
    lut_wr(5'd5, 10'd40);
    lut_wr(5'd6, 10'd100);
    add("start", ST, 0, 0, 0, 10'd0, 1, 0, 0);
    add("jump10", BR, 2'b00, 5'd1, 0, 10'd10, 1, 0, 0);
    add("call1", BR, 2'b10, 5'd2, 0, 10'd20, 1, 0, 0);
    add("call2", BR, 2'b10, 5'd4, 0, 10'd30, 1, 0, 0);
    add("call3", BR, 2'b10, 5'd5, 0, 10'd40, 1, 0, 0);
    add("call4", BR, 2'b10, 5'd6, 0, 10'd100, 1, 0, 0);
    add("ret1", BR, 2'b11, 0, 0, 10'd41, 1, 0, 0);
    add("ret2", BR, 2'b11, 0, 0, 10'd31, 1, 0, 0);
    add("ret3", BR, 2'b11, 0, 0, 10'd21, 1, 0, 0);
    add("ret4", BR, 2'b11, 0, 0, 10'd11, 1, 0, 0);
    add("ret_underflow", BR, 2'b11, 0, 0, 10'd12, 1, 0, 1);
    add("err_sticky", 0, 0, 0, 0, 10'd13, 1, 0, 1);
    add("ret_not_taken", BN, 2'b11, 0, 0, 10'd14, 1, 0, 1);
    add("halt_err", HL, 0, 0, 0, 10'd14, 0, 1, 1);
    add("restart_clears", ST, 0, 0, 0, 10'd0, 1, 0, 0);
    add("ret_empty_again", BR, 2'b11, 0, 0, 10'd1, 1, 0, 1);
    while (rows.size() > 0) begin
      apply(rows.pop_front());
      tick();
      e = sb.pop_front();
      checks++;
      if ({PC, Running, Done, StackErr} !== {e.pc, e.ru, e.dn, e.er}) begin
        failures++;
        $display("FAIL %s: got pc=%0h run=%0b done=%0b err=%0b, want pc=%0h run=%0b done=%0b err=%0b",
                 e.nm, PC, Running, Done, StackErr, e.pc, e.ru, e.dn, e.er);
      end
    end
  endtask

  task automatic test_overflow();
    restart();
    lut_wr(5'd1, 10'd10);
    lut_wr(5'd2, 10'd20);
    lut_wr(5'd4, 10'd30);
    lut_wr(5'd5, 10'd40);
    lut_wr(5'd6, 10'd100);
    lut_wr(5'd7, 10'd200);
    add("start", ST, 0, 0, 0, 10'd0, 1, 0, 0);
    add("jump10", BR, 2'b00, 5'd1, 0, 10'd10, 1, 0, 0);
    add("ocall1", BR, 2'b10, 5'd2, 0, 10'd20, 1, 0, 0);
    add("ocall2", BR, 2'b10, 5'd4, 0, 10'd30, 1, 0, 0);
    add("ocall3", BR, 2'b10, 5'd5, 0, 10'd40, 1, 0, 0);
    add("ocall4", BR, 2'b10, 5'd6, 0, 10'd100, 1, 0, 0);
    add("ocall_full", BR, 2'b10, 5'd7, 0, 10'd101, 1, 0, 1);
    add("oret1", BR, 2'b11, 0, 0, 10'd41, 1, 0, 1);
    add("oret2", BR, 2'b11, 0, 0, 10'd31, 1, 0, 1);
    add("oret3", BR, 2'b11, 0, 0, 10'd21, 1, 0, 1);
    add("oret4", BR, 2'b11, 0, 0, 10'd11, 1, 0, 1);
    add("oret_empty", BR, 2'b11, 0, 0, 10'd12, 1, 0, 1);
    while (rows.size() > 0) begin
      apply(rows.pop_front());
      tick();
      e = sb.pop_front();
      checks++;
      if ({PC, Running, Done, StackErr} !== {e.pc, e.ru, e.dn, e.er}) begin
        failures++;
        $display("FAIL %s: got pc=%0h run=%0b done=%0b err=%0b, want pc=%0h run=%0b done=%0b err=%0b",
                 e.nm, PC, Running, Done, StackErr, e.pc, e.ru, e.dn, e.er);
      end
    end
  endtask

  task automatic test_priority();
    restart();
    lut_wr(5'd3, 10'h2A);
    add("start", ST, 0, 0, 0, 10'd0, 1, 0, 0);
    add("step", 0, 0, 0, 0, 10'd1, 1, 0, 0);
    add("halt_stall_br", HL | SL | BR, 2'b00, 5'd3, 0, 10'd1, 0, 1, 0);
    add("restart", ST, 0, 0, 0, 10'd0, 1, 0, 0);
    add("step", 0, 0, 0, 0, 10'd1, 1, 0, 0);
    add("stall_br", SL | BR, 2'b00, 5'd3, 0, 10'd1, 1, 0, 0);
    add("branch_lost", 0, 0, 0, 0, 10'd2, 1, 0, 0);
    add("stall_only", SL, 0, 0, 0, 10'd2, 1, 0, 0);
    while (rows.size() > 0) begin
      apply(rows.pop_front());
      tick();
      e = sb.pop_front();
      checks++;
      if ({PC, Running, Done, StackErr} !== {e.pc, e.ru, e.dn, e.er}) begin
        failures++;
        $display("FAIL %s: got pc=%0h run=%0b done=%0b err=%0b, want pc=%0h run=%0b done=%0b err=%0b",
                 e.nm, PC, Running, Done, StackErr, e.pc, e.ru, e.dn, e.er);
      end
    end
    LutWe = 1'b1;
    LutWaddr = 5'd3;
    LutWdata = 10'h155;
    add("wr_rd_same", BR, 2'b00, 5'd3, 0, 10'h2A, 1, 0, 0);
    apply(rows.pop_front());
    tick();
    LutWe = 1'b0;
    add("wr_then_rd", BR, 2'b00, 5'd3, 0, 10'h155, 1, 0, 0);
    add("start_in_run", ST, 0, 0, 0, 10'h156, 1, 0, 0);
    add("stall_call", SL | BR, 2'b10, 5'd3, 0, 10'h156, 1, 0, 0);
    add("ret_after_lost_call", BR, 2'b11, 0, 0, 10'h157, 1, 0, 1);
    e = sb.pop_front();
    checks++;
    if ({PC, Running, Done, StackErr} !== {e.pc, e.ru, e.dn, e.er}) begin
      failures++;
      $display("FAIL %s: got pc=%0h run=%0b done=%0b err=%0b, want pc=%0h run=%0b done=%0b err=%0b",
               e.nm, PC, Running, Done, StackErr, e.pc, e.ru, e.dn, e.er);
    end
    while (rows.size() > 0) begin
      apply(rows.pop_front());
      tick();
      e = sb.pop_front();
      checks++;
      if ({PC, Running, Done, StackErr} !== {e.pc, e.ru, e.dn, e.er}) begin
        failures++;
        $display("FAIL %s: got pc=%0h run=%0b done=%0b err=%0b, want pc=%0h run=%0b done=%0b err=%0b",
                 e.nm, PC, Running, Done, StackErr, e.pc, e.ru, e.dn, e.er);
      end
    end
  endtask

  task automatic test_reset_mid();
    restart();
    lut_wr(5'd2, 10'd20);
    add("start", ST, 0, 0, 0, 10'd0, 1, 0, 0);
    add("ret_empty", BR, 2'b11, 0, 0, 10'd1, 1, 0, 1);
    add("call", BR, 2'b10, 5'd2, 0, 10'd20, 1, 0, 1);
    add("init_mid", IN | BR, 2'b11, 0, 0, 10'd0, 0, 0, 0);
    add("idle_after_init", 0, 0, 0, 0, 10'd0, 0, 0, 0);
    add("start_after_init", ST, 0, 0, 0, 10'd0, 1, 0, 0);
    add("lut_cleared", BR, 2'b00, 5'd2, 0, 10'd0, 1, 0, 0);
    add("stack_cleared", BR, 2'b11, 0, 0, 10'd1, 1, 0, 1);
    while (rows.size() > 0) begin
      apply(rows.pop_front());
      tick();
      e = sb.pop_front();
      checks++;
      if ({PC, Running, Done, StackErr} !== {e.pc, e.ru, e.dn, e.er}) begin
        failures++;
        $display("FAIL %s: got pc=%0h run=%0b done=%0b err=%0b, want pc=%0h run=%0b done=%0b err=%0b",
                 e.nm, PC, Running, Done, StackErr, e.pc, e.ru, e.dn, e.er);
      end
    end
  endtask

  initial begin
    {Init, Start, Halt, Stall, BRANCH, Cond, LutWe} = '0;
    BrMode = '0;
    LutIdx = '0;
    Offset = '0;
    LutWaddr = '0;
    LutWdata = '0;
    test_reset();
    test_seq_wrap();
    test_branches();
    test_call_return();
    test_overflow();
    test_priority();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program-counter sequencer that replaces the fixed-width fetch unit in the next-generation core. It owns the PC and a start/run/halt state machine. It resolves absolute branches through a writable target lookup table, relative branches through a signed offset, and call/return through a bounded return-address stack. It sits between the control unit (branch/halt requests) and the instruction ROM (address output).

## Interface
Parameters:
- PC_W, 10, width of the PC and of every LUT/stack entry
- LUT_AW, 5, index width of the target LUT (2^LUT_AW entries)
- STACK_DEPTH, 4, return-stack entries (≥1)
- START_PC, 0, PC value loaded on reset and on every Start

Ports:
- CLK  in  1  clock; all state updates on rising edge
- Init  in  1  synchronous, active-high reset; highest priority
- Start  in  1  leave IDLE or HALTED, begin fetch at START_PC
- Halt  in  1  halt request (sampled only in RUN)
- Stall  in  1  hold PC for one cycle (RUN only)
- BRANCH  in  1  branch request from control
- Cond  in  1  branch condition; branch taken = BRANCH & Cond
- BrMode  in  2  00 absolute via LUT, 01 relative, 10 call, 11 return
- LutIdx  in  LUT_AW  LUT index for modes 00/10
- Offset  in  8  signed two's-complement offset for mode 01
- LutWe  in  1  LUT write enable
- LutWaddr  in  LUT_AW  LUT write index
- LutWdata  in  PC_W  LUT write data
- PC  out  PC_W  registered instruction address
- Running  out  1  high in RUN
- Done  out  1  high in HALTED
- StackErr  out  1  sticky stack overflow/underflow flag

## Operation
- States: IDLE, RUN, HALTED. Reset leaves the block in IDLE.
- IDLE: PC held at START_PC. Start → RUN, with PC = START_PC.
- RUN: one next-PC decision per cycle. Priority is Halt > Stall > taken branch > PC+1.
  - Halt → HALTED; PC held.
  - Stall → PC held; a branch presented in the same cycle is discarded (the requester must re-present it).
  - Mode 00: PC ← LUT[LutIdx].
  - Mode 01: PC ← PC + sign-extend(Offset), modulo 2^PC_W.
  - Mode 10: push PC+1, then PC ← LUT[LutIdx]. On a full stack: no push, no jump, PC ← PC+1, StackErr ← 1.
  - Mode 11: pop, PC ← popped value. On an empty stack: PC ← PC+1, StackErr ← 1.
  - Not taken: PC ← PC+1, wrapping from 2^PC_W−1 to 0.
- HALTED: PC held. Start → RUN with PC = START_PC, stack pointer ← 0, StackErr ← 0.
- Start while in RUN is ignored.
- LUT read is combinational. LUT write happens at the edge, in any state.
  - A same-cycle write and read of one index returns the old value.
- Stack is LIFO with pointer 0..STACK_DEPTH. Full = pointer == STACK_DEPTH.
- Call and return never occur in the same cycle (BrMode is single-valued).
- Init in any state, including mid-branch or mid-call:
  - state ← IDLE, PC ← START_PC, stack pointer ← 0, StackErr ← 0, all LUT entries ← 0.

## Timing
- Reset values: PC = START_PC, Running = 0, Done = 0, StackErr = 0.
- All outputs are registered. Any decision made in cycle N is visible on PC in cycle N+1.
- Start latency is 1 cycle: Running rises, and PC = START_PC is valid for the first fetch.
- Halt latency is 1 cycle: Done rises and Running falls together. PC keeps the halting instruction's address.
- StackErr rises in the cycle after the offending call or return and stays high until Init or Start-from-HALTED.
- A LUT write at edge N is usable by a branch decided in cycle N+1.

## Test plan
- Sequential run and wrap: PC_W=4. Init, then Start. PC steps 0,1,…,15,0. Halt when PC=5 → PC stays 5, Done=1 next cycle.
- Absolute and relative branches: write LUT[3]=0x2A. At PC=4, mode 00 with idx 3 → PC=0x2A. Then mode 01 with Offset=−2 → PC=0x28. Same requests with Cond=0 → 0x2B.
- Call/return nesting: depth 4. Issue four calls from PCs 10, 20, 30, 40. Four returns give 41, 31, 21, 11. A fifth return gives PC+1 and StackErr=1.
- Stack overflow: issue five calls. The fifth gives PC+1 with no push and StackErr=1. The next return yields the fourth pushed address.
- Priority: Halt+Stall+branch in one cycle → HALTED, PC unchanged. Stall+branch → PC unchanged and branch lost. LUT write and branch to the same index in one cycle → old target used.
- Reset mid-operation: Init asserted in RUN with a non-empty stack and StackErr=1 → next cycle PC=START_PC, IDLE, all flags 0. LUT reads 0 and the stack is empty after Start.
